// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding four byte requesters into one UART transmitter,
// with a per-frame watchdog that aborts a frame whose tx_done never arrives.
module uart_tx_arb #(
  parameter int unsigned CLKS_PER_BIT = 3,
  parameter int unsigned TIMEOUT      = CLKS_PER_BIT * 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] data_in,
  output logic [3:0]  ack,
  output logic [3:0]  done,
  output logic        timeout_err,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic [1:0]  owner,
  output logic        arb_busy
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [1:0]        last_grant_q, last_grant_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        ack_q, ack_d;
  logic [3:0]        done_q, done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [1:0]        owner_q, owner_d;

  logic [1:0]        win;
  logic [1:0]        idx;
  logic              found;

  // Scan starts one past the last grant so every requester gets a turn.
  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = last_grant_q + 2'(i + 1);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    ack_d         = 4'b0000;
    done_d        = 4'b0000;
    timeout_err_d = 1'b0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    owner_d       = owner_q;

    unique case (state_q)
      StIdle: begin
        if (found && !tx_busy) begin
          state_d      = StSend;
          cnt_d        = '0;
          owner_d      = win;
          tx_data_d    = data_in[{win, 3'b000} +: 8];
          ack_d[win]   = 1'b1;
          tx_start_d   = 1'b1;
        end
      end
      StSend: begin
        // tx_done takes precedence over a watchdog expiry on the same edge.
        if (tx_done) begin
          done_d[owner_q] = 1'b1;
          last_grant_d    = owner_q;
          cnt_d           = '0;
          state_d         = StIdle;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          last_grant_d  = owner_q;
          cnt_d         = '0;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      last_grant_q  <= 2'd3;
      cnt_q         <= '0;
      ack_q         <= 4'b0000;
      done_q        <= 4'b0000;
      timeout_err_q <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      owner_q       <= 2'd0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      owner_q       <= owner_d;
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign owner       = owner_q;
  assign arb_busy    = (state_q == StSend);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: rotation, fixed requester, busy hold,
// watchdog, mid-frame reset and tx_done corner cases.
module tb_uart_tx_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        timeout_err;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  owner;
  logic        arb_busy;

  int tests_run;
  int tests_failed;
  int cyc;

  uart_tx_arb #(
    .CLKS_PER_BIT(3),
    .TIMEOUT(36)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .data_in(data_in),
    .ack(ack),
    .done(done),
    .timeout_err(timeout_err),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .owner(owner),
    .arb_busy(arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b0000; data_in = 32'h0; tx_busy = 1'b0; tx_done = 1'b0;
    #3;
    tests_run++;
    if ({ack, done, timeout_err, tx_start, tx_data, owner, arb_busy} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ack=%b done=%b to=%b st=%b data=%h own=%0d busy=%b, want all 0",
               ack, done, timeout_err, tx_start, tx_data, owner, arb_busy);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  // REQ: rotation 0,1,2,3,0 with tx_done driven 20 cycles after each tx_start.
  task automatic test_round_robin();
    logic [7:0] exp_data [4];
    int k;
    exp_data[0] = 8'hAA; exp_data[1] = 8'hBB; exp_data[2] = 8'hCC; exp_data[3] = 8'hDD;
    req = 4'b1111; data_in = 32'hDDCCBBAA;
    for (int f = 0; f < 5; f++) begin
      k = f % 4;
      tick();
      tests_run++;
      if (tx_start !== 1'b1 || ack !== (4'b0001 << k) || owner !== 2'(k) ||
          tx_data !== exp_data[k] || done !== 4'b0000) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: got st=%b ack=%b own=%0d data=%h done=%b, want st=1 ack=%b own=%0d data=%h done=0000",
                 f, tx_start, ack, owner, tx_data, done, 4'b0001 << k, k, exp_data[k]);
      end
      tick();
      tests_run++;
      if (ack !== 4'b0000 || tx_start !== 1'b0 || arb_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_ack_single%0d: got ack=%b st=%b busy=%b, want ack=0000 st=0 busy=1",
                 f, ack, tx_start, arb_busy);
      end
      repeat (19) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tests_run++;
      if (done !== (4'b0001 << k) || timeout_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_done%0d: got done=%b to=%b, want done=%b to=0",
                 f, done, timeout_err, 4'b0001 << k);
      end
    end
    req = 4'b0000;
    tick();
    tests_run++;
    if (done !== 4'b0000 || arb_busy !== 1'b0 || tx_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_idle: got done=%b busy=%b st=%b, want 0000 0 0", done, arb_busy, tx_start);
    end
  endtask

  // Only requester 2 asks; tx_start spacing must be latency + 2.
  task automatic test_fixed_requester();
    int prev;
    prev = 0;
    req = 4'b0100;
    for (int f = 0; f < 3; f++) begin
      tick();
      tests_run++;
      if (tx_start !== 1'b1 || owner !== 2'd2 || ack !== 4'b0100 || tx_data !== 8'hCC) begin
        tests_failed++;
        $display("FAIL fixed_grant%0d: got st=%b own=%0d ack=%b data=%h, want 1 2 0100 cc",
                 f, tx_start, owner, ack, tx_data);
      end
      if (f > 0) begin
        tests_run++;
        if (cyc - prev !== 7) begin
          tests_failed++;
          $display("FAIL fixed_spacing%0d: got %0d cycles, want 7", f, cyc - prev);
        end
      end
      prev = cyc;
      repeat (5) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tests_run++;
      if (done !== 4'b0100) begin
        tests_failed++;
        $display("FAIL fixed_done%0d: got done=%b, want 0100", f, done);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  // Requests are held off while the transmitter is busy.
  task automatic test_busy_hold();
    int starts;
    starts = 0;
    tx_busy = 1'b1;
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_start !== 1'b0 || arb_busy !== 1'b0) starts++;
    end
    tests_run++;
    if (starts !== 0) begin
      tests_failed++;
      $display("FAIL busy_no_start: got %0d cycles with grant activity, want 0", starts);
    end
    tx_busy = 1'b0;
    tick();
    tests_run++;
    if (tx_start !== 1'b1 || owner !== 2'd0 || ack !== 4'b0001) begin
      tests_failed++;
      $display("FAIL busy_release: got st=%b own=%0d ack=%b, want 1 0 0001", tx_start, owner, ack);
    end
    req = 4'b0000;
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tests_run++;
    if (done !== 4'b0001) begin
      tests_failed++;
      $display("FAIL busy_done: got done=%b, want 0001", done);
    end
    tick();
  endtask

  // Requester 1 never completes; watchdog fires 36 cycles after entry.
  task automatic test_timeout();
    int at;
    int pulses;
    int bad_done;
    at = -1; pulses = 0; bad_done = 0;
    req = 4'b0010;
    tick();
    tests_run++;
    if (tx_start !== 1'b1 || owner !== 2'd1) begin
      tests_failed++;
      $display("FAIL to_grant: got st=%b own=%0d, want 1 1", tx_start, owner);
    end
    req = 4'b0000;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done !== 4'b0000) bad_done++;
      if (timeout_err === 1'b1) begin
        pulses++;
        if (at < 0) at = i;
      end
    end
    tests_run++;
    if (at !== 36 || pulses !== 1) begin
      tests_failed++;
      $display("FAIL to_pulse: got first at %0d, %0d pulses; want at 36, 1 pulse", at, pulses);
    end
    tests_run++;
    if (bad_done !== 0) begin
      tests_failed++;
      $display("FAIL to_no_done: got %0d done cycles, want 0", bad_done);
    end
    req = 4'b0110;
    tick();
    tests_run++;
    if (tx_start !== 1'b1 || owner !== 2'd2 || ack !== 4'b0100) begin
      tests_failed++;
      $display("FAIL to_next_grant: got st=%b own=%0d ack=%b, want 1 2 0100", tx_start, owner, ack);
    end
    req = 4'b0000;
    repeat (2) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tests_run++;
    if (done !== 4'b0100) begin
      tests_failed++;
      $display("FAIL to_next_done: got done=%b, want 0100", done);
    end
    tick();
  endtask

  // Reset in the middle of a frame clears everything and restores priority to 0.
  task automatic test_reset_mid_send();
    int stray;
    stray = 0;
    req = 4'b1000;
    tick();
    tests_run++;
    if (owner !== 2'd3 || tx_start !== 1'b1 || tx_data !== 8'hDD) begin
      tests_failed++;
      $display("FAIL rst_pre_grant: got own=%0d st=%b data=%h, want 3 1 dd", owner, tx_start, tx_data);
    end
    repeat (4) tick();
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({ack, done, timeout_err, tx_start, tx_data, owner, arb_busy} !== 21'd0) begin
      tests_failed++;
      $display("FAIL rst_async_clear: got ack=%b done=%b to=%b st=%b data=%h own=%0d busy=%b, want all 0",
               ack, done, timeout_err, tx_start, tx_data, owner, arb_busy);
    end
    req = 4'b1001;
    tx_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done !== 4'b0000 || timeout_err !== 1'b0 || tx_start !== 1'b0) stray++;
    end
    tx_done = 1'b0;
    tests_run++;
    if (stray !== 0) begin
      tests_failed++;
      $display("FAIL rst_hold_quiet: got %0d active cycles in reset, want 0", stray);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (tx_start !== 1'b1 || owner !== 2'd0 || ack !== 4'b0001 || tx_data !== 8'hAA) begin
      tests_failed++;
      $display("FAIL rst_first_grant: got st=%b own=%0d ack=%b data=%h, want 1 0 0001 aa",
               tx_start, owner, ack, tx_data);
    end
    req = 4'b0000;
    repeat (2) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tests_run++;
    if (done !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rst_first_done: got done=%b, want 0001", done);
    end
    tick();
  endtask

  // A tx_done pulse in IDLE must leave every output untouched.
  task automatic test_stray_done();
    req = 4'b0000;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tests_run++;
    if ({ack, done, timeout_err, tx_start, arb_busy} !== 11'd0 || owner !== 2'd0 ||
        tx_data !== 8'hAA) begin
      tests_failed++;
      $display("FAIL stray_done: got ack=%b done=%b to=%b st=%b busy=%b own=%0d data=%h, want 0s own=0 data=aa",
               ack, done, timeout_err, tx_start, arb_busy, owner, tx_data);
    end
    tick();
    tests_run++;
    if (done !== 4'b0000 || arb_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stray_done_after: got done=%b busy=%b, want 0000 0", done, arb_busy);
    end
  endtask

  // tx_done on the watchdog's final cycle wins over timeout_err.
  task automatic test_done_vs_timeout();
    req = 4'b0010;
    tick();
    tests_run++;
    if (owner !== 2'd1 || tx_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL tie_grant: got own=%0d st=%b, want 1 1", owner, tx_start);
    end
    req = 4'b0000;
    repeat (35) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tests_run++;
    if (done !== 4'b0010 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL tie_done_wins: got done=%b to=%b, want 0010 0", done, timeout_err);
    end
    tick();
    tests_run++;
    if (timeout_err !== 1'b0 || done !== 4'b0000 || arb_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL tie_after: got to=%b done=%b busy=%b, want 0 0000 0", timeout_err, done, arb_busy);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    test_reset();
    test_round_robin();
    test_fixed_requester();
    test_busy_hold();
    test_timeout();
    test_reset_mid_send();
    test_stray_done();
    test_done_vs_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
